// File: rtl/riscv_pkg.sv
// Shared core-wide definitions used by the data-memory port arbiter.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Loader/debug master valid/ready request channel plus its registered read-return.
interface dmem_port_arbiter_if #(
    parameter int XLEN = riscv_pkg::XLEN
) ();

    logic            ld_valid;
    logic            ld_ready;
    logic            ld_we;
    logic [XLEN-1:0] ld_addr;
    logic [XLEN-1:0] ld_wdata;
    logic            ld_rvalid;
    logic [XLEN-1:0] ld_rdata;

    modport master (
        output ld_valid,
        output ld_we,
        output ld_addr,
        output ld_wdata,
        input  ld_ready,
        input  ld_rvalid,
        input  ld_rdata
    );

    modport slave (
        input  ld_valid,
        input  ld_we,
        input  ld_addr,
        input  ld_wdata,
        output ld_ready,
        output ld_rvalid,
        output ld_rdata
    );

endinterface

// File: rtl/dmem_port_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles a pending loader request lost the port.
module arb_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int              W   = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0]    SAT = W'(MAX_WAIT);

    logic [W-1:0] cnt_q, cnt_d;

    assign sat_o = (cnt_q == SAT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory port between the MEM stage and a loader, with halt handshake.
// Optional perf counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN     = riscv_pkg::XLEN,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemReqM,
    input  logic               MemWriteM,
    input  logic [XLEN-1:0]    ALUResultM,
    input  logic [XLEN-1:0]    WriteDataM,
    output logic [XLEN-1:0]    ReadDataM,
    output logic               StallM,
    dmem_port_arbiter_if.slave ld,
    input  logic               halt_req,
    output logic               halt_ack,
    output logic               mem_w_en,
    output logic [XLEN-1:0]    mem_addr,
    output logic [XLEN-1:0]    mem_w_d,
    input  logic [XLEN-1:0]    mem_r_d
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_ldr_cnt
`endif
);

    arb_state_t      state_q, state_d;
    logic            halted;
    logic            ldr_gnt;
    logic            rd_gnt;
    logic            starve_sat;
    logic            starve_inc;
    logic            starve_clr;
    logic            ld_rvalid_q;
    logic [XLEN-1:0] ld_rdata_q;

    assign halted     = (state_q == HALTED);
    // Every combinational grant/write is gated by rst so nothing leaks out during reset.
    assign ldr_gnt    = rst & ld.ld_valid & (halted | ~MemReqM | starve_sat);
    assign rd_gnt     = ldr_gnt & ~ld.ld_we;
    assign starve_inc = ld.ld_valid & MemReqM & ~ldr_gnt;
    assign starve_clr = ldr_gnt | ~ld.ld_valid;

    arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat)
    );

    always_comb begin
        state_d     = state_q;
        StallM      = 1'b0;
        mem_w_en    = 1'b0;
        mem_addr    = ALUResultM;
        mem_w_d     = WriteDataM;
        ld.ld_ready = ldr_gnt;

        case (state_q)
            RUN:     if (halt_req)  state_d = HALTED;
            HALTED:  if (!halt_req) state_d = RUN;
            default: state_d = RUN;
        endcase

        if (rst) begin
            StallM = halted | (MemReqM & ldr_gnt);
            if (ldr_gnt) begin
                mem_addr = ld.ld_addr;
                mem_w_d  = ld.ld_wdata;
                mem_w_en = ld.ld_we;
            end else begin
                // A stalled MEM store is held off here and retried once StallM drops.
                mem_w_en = MemReqM & MemWriteM & ~halted & ~StallM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            ld_rvalid_q <= 1'b0;
            ld_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            ld_rvalid_q <= rd_gnt;
            if (rd_gnt) begin
                ld_rdata_q <= mem_r_d;
            end
        end
    end

    assign ReadDataM    = mem_r_d;
    assign halt_ack     = halted;
    assign ld.ld_rvalid = ld_rvalid_q;
    assign ld.ld_rdata  = ld_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_ldr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_ldr_q   <= '0;
        end else begin
            if (StallM && !halted) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (ldr_gnt) begin
                perf_ldr_q <= perf_ldr_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_ldr_cnt   = perf_ldr_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed and randomized bench for dmem_port_arbiter against a cycle-level behavioural model.
module tb_dmem_port_arbiter;
    import riscv_pkg::*;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemReqM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, halt_req, halt_ack, mem_w_en;
    logic [31:0] mem_addr, mem_w_d, mem_r_d;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_ldr_cnt;
`endif

    dmem_port_arbiter_if ldif ();

    dmem_port_arbiter #(.XLEN(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .ld         (ldif),
        .halt_req   (halt_req),
        .halt_ack   (halt_ack),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_w_d    (mem_w_d),
        .mem_r_d    (mem_r_d)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_ldr_cnt   (perf_ldr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT and the model's own view of what it must contain.
    logic [31:0] dmem      [256];
    logic [31:0] model_mem [256];

    always @(posedge clk) if (mem_w_en) dmem[mem_addr[9:2]] <= mem_w_d;
    assign mem_r_d = dmem[mem_addr[9:2]];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state and the next-state staged at the preceding negedge.
    bit          m_live = 1'b0;
    bit          m_halted, m_rvalid;
    int          m_loss;
    logic [31:0] m_rdata;
    bit          n_halted, n_rvalid, n_wen, n_gnt, n_sinc;
    int          n_loss;
    logic [31:0] n_rdata, n_waddr, n_wdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] m_stall_cnt, m_ldr_cnt;
`endif

    always @(negedge clk) begin : cmp_p
        bit          gnt, stall, wen;
        logic [31:0] addr, wd;
        if (m_live) begin
            if (!rst) begin
                chk("rst_ld_ready", {31'd0, ldif.ld_ready}, 32'd0);
                chk("rst_StallM", {31'd0, StallM}, 32'd0);
                chk("rst_mem_w_en", {31'd0, mem_w_en}, 32'd0);
                n_wen <= 1'b0;
            end else begin
                gnt   = ldif.ld_valid && (m_halted || !MemReqM || m_loss == MAX_WAIT);
                stall = m_halted || (MemReqM && gnt);
                wen   = gnt ? ldif.ld_we : (MemReqM && MemWriteM && !stall);
                addr  = gnt ? ldif.ld_addr : ALUResultM;
                wd    = gnt ? ldif.ld_wdata : WriteDataM;
                chk("ld_ready", {31'd0, ldif.ld_ready}, {31'd0, gnt});
                chk("StallM", {31'd0, StallM}, {31'd0, stall});
                chk("mem_w_en", {31'd0, mem_w_en}, {31'd0, wen});
                if (wen) begin
                    chk("mem_addr", mem_addr, addr);
                    chk("mem_w_d", mem_w_d, wd);
                end
                chk("ReadDataM", ReadDataM, model_mem[addr[9:2]]);
                chk("halt_ack", {31'd0, halt_ack}, {31'd0, m_halted});
                chk("ld_rvalid", {31'd0, ldif.ld_rvalid}, {31'd0, m_rvalid});
                chk("ld_rdata", ldif.ld_rdata, m_rdata);
`ifdef DMEM_ARB_PERF_EN
                chk("perf_stall_cnt", perf_stall_cnt, m_stall_cnt);
                chk("perf_ldr_cnt", perf_ldr_cnt, m_ldr_cnt);
`endif
                n_wen    <= wen;
                n_waddr  <= addr;
                n_wdata  <= wd;
                n_gnt    <= gnt;
                n_sinc   <= stall && !m_halted;
                n_rvalid <= gnt && !ldif.ld_we;
                n_rdata  <= (gnt && !ldif.ld_we) ? model_mem[addr[9:2]] : m_rdata;
                n_halted <= halt_req;
                if (gnt || !ldif.ld_valid) n_loss <= 0;
                else if (MemReqM)          n_loss <= (m_loss < MAX_WAIT) ? m_loss + 1 : MAX_WAIT;
                else                       n_loss <= m_loss;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            m_live   <= 1'b1;
            m_halted <= 1'b0;
            m_loss   <= 0;
            m_rvalid <= 1'b0;
            m_rdata  <= 32'd0;
`ifdef DMEM_ARB_PERF_EN
            m_stall_cnt <= 32'd0;
            m_ldr_cnt   <= 32'd0;
`endif
        end else if (m_live) begin
            if (n_wen) model_mem[n_waddr[9:2]] <= n_wdata;
            m_halted <= n_halted;
            m_loss   <= n_loss;
            m_rvalid <= n_rvalid;
            m_rdata  <= n_rdata;
`ifdef DMEM_ARB_PERF_EN
            m_stall_cnt <= m_stall_cnt + {31'd0, n_sinc};
            m_ldr_cnt   <= m_ldr_cnt + {31'd0, n_gnt};
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ldr(input bit v, input bit we, input logic [31:0] a, input logic [31:0] d);
        ldif.ld_valid = v;
        ldif.ld_we    = we;
        ldif.ld_addr  = a;
        ldif.ld_wdata = d;
    endtask

    task automatic mem_stage(input bit req, input bit wr, input logic [31:0] a, input logic [31:0] d);
        MemReqM    = req;
        MemWriteM  = wr;
        ALUResultM = a;
        WriteDataM = d;
    endtask

    initial begin
        bit pr, ps;
        for (int i = 0; i < 256; i++) begin
            dmem[i]      <= 32'(i) * 32'h0101_0101;
            model_mem[i] <= 32'(i) * 32'h0101_0101;
        end
        rst = 1'b0;
        halt_req = 1'b0;
        // Reset gating with both requesters active
        ldr(1'b1, 1'b0, 32'h10, 32'h0);
        mem_stage(1'b1, 1'b1, 32'h40, 32'h99);
        @(negedge clk);
        chk("t1_ready", {31'd0, ldif.ld_ready}, 32'd0);
        chk("t1_stall", {31'd0, StallM}, 32'd0);
        chk("t1_wen", {31'd0, mem_w_en}, 32'd0);
        step();
        rst = 1'b1;
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        mem_stage(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_halt_ack", {31'd0, halt_ack}, 32'd0);
        chk("t1_rvalid", {31'd0, ldif.ld_rvalid}, 32'd0);

        // No contention: write then read back
        step();
        ldr(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_wr_ready", {31'd0, ldif.ld_ready}, 32'd1);
        chk("t2_wr_wen", {31'd0, mem_w_en}, 32'd1);
        step();
        ldr(1'b1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t2_rd_ready", {31'd0, ldif.ld_ready}, 32'd1);
        step();
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t2_rvalid", {31'd0, ldif.ld_rvalid}, 32'd1);
        chk("t2_rdata", ldif.ld_rdata, 32'hDEAD_BEEF);

        // Starvation bound: grant on every fifth cycle
        step();
        mem_stage(1'b1, 1'b0, 32'h40, 32'h0);
        ldr(1'b1, 1'b0, 32'h10, 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_ready", {31'd0, ldif.ld_ready}, {31'd0, (k % 5) == 4});
            chk("t3_stall", {31'd0, StallM}, {31'd0, (k % 5) == 4});
            if (k % 5 == 0 && k > 0) begin
                chk("t3_rvalid", {31'd0, ldif.ld_rvalid}, 32'd1);
                chk("t3_rdata", ldif.ld_rdata, 32'hDEAD_BEEF);
            end
            step();
        end

        // Stalled MEM store collides with a granted loader write
        ldr(1'b1, 1'b1, 32'h24, 32'hAA);
        mem_stage(1'b1, 1'b0, 32'h40, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t4_lose", {31'd0, ldif.ld_ready}, 32'd0);
            step();
        end
        mem_stage(1'b1, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        chk("t4_n_ready", {31'd0, ldif.ld_ready}, 32'd1);
        chk("t4_n_stall", {31'd0, StallM}, 32'd1);
        chk("t4_n_wen", {31'd0, mem_w_en}, 32'd1);
        chk("t4_n_addr", mem_addr, 32'h24);
        chk("t4_n_wd", mem_w_d, 32'hAA);
        step();
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_n1_stall", {31'd0, StallM}, 32'd0);
        chk("t4_n1_wen", {31'd0, mem_w_en}, 32'd1);
        chk("t4_n1_addr", mem_addr, 32'h20);
        chk("t4_n1_wd", mem_w_d, 32'h55);
        step();
        mem_stage(1'b0, 1'b0, 32'h0, 32'h0);
        ldr(1'b1, 1'b0, 32'h24, 32'h0);
        step();
        ldr(1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        chk("t4_rd24", ldif.ld_rdata, 32'hAA);
        step();
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t4_rd20", ldif.ld_rdata, 32'h55);
        chk("t4_mem24", dmem[9], 32'hAA);
        chk("t4_mem20", dmem[8], 32'h55);

        // Halt handshake with back-to-back loader fill
        step();
        halt_req = 1'b1;
        @(negedge clk);
        chk("t5_ack_pre", {31'd0, halt_ack}, 32'd0);
        step();
        mem_stage(1'b1, 1'b1, 32'h30, 32'h77);
        @(negedge clk);
        chk("t5_ack", {31'd0, halt_ack}, 32'd1);
        chk("t5_stall", {31'd0, StallM}, 32'd1);
        chk("t5_nowrite", {31'd0, mem_w_en}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            ldr(1'b1, 1'b1, 32'h80 + 32'(4 * i), 32'h1000 + 32'(i));
            @(negedge clk);
            chk("t5_fill_ready", {31'd0, ldif.ld_ready}, 32'd1);
            chk("t5_fill_wen", {31'd0, mem_w_en}, 32'd1);
            chk("t5_fill_stall", {31'd0, StallM}, 32'd1);
        end
        step();
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        halt_req = 1'b0;
        @(negedge clk);
        chk("t5_last_stall", {31'd0, StallM}, 32'd1);
        chk("t5_last_wen", {31'd0, mem_w_en}, 32'd0);
        step();
        @(negedge clk);
        chk("t5_run_ack", {31'd0, halt_ack}, 32'd0);
        chk("t5_run_stall", {31'd0, StallM}, 32'd0);
        chk("t5_run_wen", {31'd0, mem_w_en}, 32'd1);
        chk("t5_run_addr", mem_addr, 32'h30);
        step();
        mem_stage(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) chk("t5_fill_mem", dmem[32 + i], 32'h1000 + 32'(i));
        chk("t5_store_mem", dmem[12], 32'h77);

        // Reset lands on the edge right after a granted read
        step();
        ldr(1'b1, 1'b0, 32'h80, 32'h0);
        @(negedge clk);
        chk("t6_ready", {31'd0, ldif.ld_ready}, 32'd1);
        #1;
        rst = 1'b0;
        step();
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t6_rvalid", {31'd0, ldif.ld_rvalid}, 32'd0);
        chk("t6_rdata", ldif.ld_rdata, 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk("t6_perf_stall", perf_stall_cnt, 32'd0);
        chk("t6_perf_ldr", perf_ldr_cnt, 32'd0);
`endif
        step();
        rst = 1'b1;

        // Randomized traffic; both requesters hold their request until accepted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            pr = ldif.ld_ready;
            ps = StallM;
            step();
            rst = ($urandom_range(199) != 0);
            if ($urandom_range(39) == 0) halt_req = !halt_req;
            if (!(ldif.ld_valid && !pr))
                ldr($urandom_range(9) < 6, 1'($urandom_range(1)),
                    32'($urandom_range(31)) << 2, $urandom);
            if (!(MemReqM && ps))
                mem_stage(1'($urandom_range(1)), 1'($urandom_range(1)),
                          32'($urandom_range(31)) << 2, $urandom);
        end
        rst = 1'b1;
        halt_req = 1'b0;
        ldr(1'b0, 1'b0, 32'h0, 32'h0);
        mem_stage(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        @(negedge clk);
        for (int i = 0; i < 256; i++) chk("final_mem", dmem[i], model_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
